// File: rtl/if_stage_param.sv
// Instruction-fetch stage. It drives the PC and the ID instruction register, and handles
// flush, jump, load-use stall, halt and I-cache wait. Define IF_PERF_CNT_EN to enable the stall/flush counters.
module if_stage_param #(
  parameter int          PC_W     = 8,
  parameter logic [15:0] RESET_PC = 16'h0000,
  parameter int          CNT_W    = 16
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             state,
  input  logic             cf,
  input  logic             nf,
  input  logic             zf,
  input  logic [15:0]      alu_o,
  input  logic [15:0]      ex_ir,
  output logic             i_req,
  output logic [PC_W-1:0]  i_addr,
  input  logic [15:0]      i_datain,
  input  logic             i_ready,
  output logic [PC_W-1:0]  pc,
  output logic [15:0]      id_ir,
  output logic             id_valid,
  output logic             halted,
  output logic [2:0]       bug,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt
);

  localparam logic [4:0] OP_HALT = 5'b00001, OP_LOAD = 5'b00010, OP_STORE = 5'b00011,
                         OP_SLL  = 5'b00100, OP_SRL  = 5'b00101, OP_SLA   = 5'b00110,
                         OP_SRA  = 5'b00111, OP_ADD  = 5'b01000, OP_ADDI  = 5'b01001,
                         OP_SUB  = 5'b01010, OP_SUBI = 5'b01011, OP_CMP   = 5'b01100,
                         OP_AND  = 5'b01101, OP_OR   = 5'b01110, OP_LDIH  = 5'b10000,
                         OP_ADDC = 5'b10001, OP_SUBC = 5'b10010, OP_JUMP  = 5'b11000,
                         OP_JMPR = 5'b11001, OP_BZ   = 5'b11010, OP_BNZ   = 5'b11011,
                         OP_BN   = 5'b11100, OP_BNN  = 5'b11101, OP_BC    = 5'b11110,
                         OP_BNC  = 5'b11111;

  localparam logic [2:0] B_JUMP = 3'b010, B_FLUSH = 3'b011, B_LU = 3'b100,
                         B_ADV  = 3'b101, B_WAIT  = 3'b110, B_HALT = 3'b111;

  logic [4:0] ex_op, id_op, in_op;
  logic [2:0] rd;
  logic       br_taken, rd_hit;
  logic [2:0] nbug;
  logic       unused_bits;

  assign ex_op  = ex_ir[15:11];
  assign id_op  = id_ir[15:11];
  assign in_op  = i_datain[15:11];
  assign rd     = id_ir[10:8];
  assign i_req  = state & ~halted;
  assign i_addr = pc;
  assign unused_bits = ^{alu_o, ex_ir[10:0], i_datain[7], i_datain[3]};

  always_comb begin
    br_taken = 1'b0;
    case (ex_op)
      OP_JMPR: br_taken = 1'b1;
      OP_BZ:   br_taken = zf;
      OP_BNZ:  br_taken = ~zf;
      OP_BN:   br_taken = nf;
      OP_BNN:  br_taken = ~nf;
      OP_BC:   br_taken = cf;
      OP_BNC:  br_taken = ~cf;
      default: br_taken = 1'b0;
    endcase
  end

  // Does the instruction arriving from the cache read the register the LOAD in ID writes?
  always_comb begin
    rd_hit = 1'b0;
    case (in_op)
      OP_ADD, OP_SUB, OP_CMP, OP_ADDC, OP_SUBC, OP_AND, OP_OR:
        rd_hit = (i_datain[6:4] == rd) || (i_datain[2:0] == rd);
      OP_ADDI, OP_SUBI, OP_LDIH, OP_JMPR, OP_BZ, OP_BNZ, OP_BN, OP_BNN, OP_BC, OP_BNC:
        rd_hit = (i_datain[10:8] == rd);
      OP_SLL, OP_SLA, OP_SRL, OP_SRA, OP_LOAD:
        rd_hit = (i_datain[6:4] == rd);
      OP_STORE:
        rd_hit = (i_datain[10:8] == rd) || (i_datain[6:4] == rd);
      default: rd_hit = 1'b0;
    endcase
  end

  // Priority-encoded action; the bug code doubles as the action selector.
  always_comb begin
    if (br_taken)                                      nbug = B_FLUSH;
    else if (id_valid && id_op == OP_JUMP)             nbug = B_JUMP;
    else if (id_valid && id_op == OP_LOAD && i_ready && rd_hit) nbug = B_LU;
    else if (id_valid && id_op == OP_HALT)             nbug = B_HALT;
    else if (!i_ready)                                 nbug = B_WAIT;
    else                                               nbug = B_ADV;
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      pc       <= RESET_PC[PC_W-1:0];
      id_ir    <= '0;
      id_valid <= 1'b0;
      halted   <= 1'b0;
      bug      <= 3'b000;
    end else if (state) begin
      bug <= nbug;
      case (nbug)
        B_FLUSH: begin
          pc       <= alu_o[PC_W-1:0];
          id_ir    <= '0;
          id_valid <= 1'b0;
          halted   <= 1'b0;
        end
        B_JUMP: begin
          pc       <= PC_W'(id_ir[7:0]);
          id_ir    <= '0;
          id_valid <= 1'b0;
        end
        B_LU, B_WAIT: begin
          id_ir    <= '0;
          id_valid <= 1'b0;
        end
        B_HALT: halted <= 1'b1;
        default: begin
          pc       <= pc + 1'b1;
          id_ir    <= i_datain;
          id_valid <= 1'b1;
        end
      endcase
    end
  end

`ifdef IF_PERF_CNT_EN
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      stall_cnt <= '0;
      flush_cnt <= '0;
    end else if (state) begin
      if ((nbug == B_LU || nbug == B_WAIT) && stall_cnt != '1) stall_cnt <= stall_cnt + 1'b1;
      if ((nbug == B_FLUSH || nbug == B_JUMP) && flush_cnt != '1) flush_cnt <= flush_cnt + 1'b1;
    end
  end
`else
  assign stall_cnt = '0;
  assign flush_cnt = '0;
`endif

endmodule

// File: tb/tb_if_stage_param.sv
// Directed bench for if_stage_param (PC_W=8): straight line, branches, jump, load-use,
// miss with wrap, halt/flush, idle hold and async reset mid-miss.
module tb_if_stage_param;
  localparam int PC_W = 8;
  localparam int CNT_W = 16;
`ifdef IF_PERF_CNT_EN
  localparam bit PERF = 1'b1;
`else
  localparam bit PERF = 1'b0;
`endif

  logic clock = 1'b0, reset, state, cf, nf, zf, i_ready, i_req, id_valid, halted;
  logic [15:0] alu_o, ex_ir, i_datain, id_ir;
  logic [PC_W-1:0] i_addr, pc;
  logic [2:0] bug;
  logic [CNT_W-1:0] stall_cnt, flush_cnt;
  int n_cmp = 0, n_err = 0;

  if_stage_param #(.PC_W(PC_W), .RESET_PC(16'h0000), .CNT_W(CNT_W)) dut (
    .clock(clock), .reset(reset), .state(state), .cf(cf), .nf(nf), .zf(zf),
    .alu_o(alu_o), .ex_ir(ex_ir), .i_req(i_req), .i_addr(i_addr), .i_datain(i_datain),
    .i_ready(i_ready), .pc(pc), .id_ir(id_ir), .id_valid(id_valid), .halted(halted),
    .bug(bug), .stall_cnt(stall_cnt), .flush_cnt(flush_cnt));

  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic chk_st(input string tag, input logic [7:0] epc, input logic [15:0] eir,
                        input logic evld, input logic [2:0] ebug);
    chk({tag, ".pc"}, pc, epc);
    chk({tag, ".id_ir"}, id_ir, eir);
    chk({tag, ".id_valid"}, id_valid, evld);
    chk({tag, ".bug"}, bug, ebug);
  endtask

  initial begin
    reset = 1'b0; state = 1'b0; cf = 0; nf = 0; zf = 0; i_ready = 0;
    alu_o = '0; ex_ir = '0; i_datain = '0;
    #12;
    chk_st("reset", 8'h00, 16'h0000, 1'b0, 3'b000);
    chk("reset.halted", halted, 1'b0);
    chk("reset.i_req", i_req, 1'b0);
    chk("reset.stall_cnt", stall_cnt, 0);
    chk("reset.flush_cnt", flush_cnt, 0);
    reset = 1'b1;

    // straight line of ADD r1,r2,r3
    state = 1'b1; i_ready = 1'b1; i_datain = 16'h4123;
    #1 chk("run.i_req", i_req, 1'b1);
    chk("run.i_addr", i_addr, 8'h00);
    tick(); chk_st("adv1", 8'h01, 16'h4123, 1'b1, 3'b101);
    tick(); chk_st("adv2", 8'h02, 16'h4123, 1'b1, 3'b101);
    tick(); chk_st("adv3", 8'h03, 16'h4123, 1'b1, 3'b101);
    chk("adv3.i_addr", i_addr, 8'h03);

    // taken BZ
    ex_ir = 16'hD000; zf = 1'b1; alu_o = 16'h0040;
    tick(); chk_st("bz_taken", 8'h40, 16'h0000, 1'b0, 3'b011);
    zf = 1'b0;
    tick(); chk_st("bz_not", 8'h41, 16'h4123, 1'b1, 3'b101);
    // taken BNC
    ex_ir = 16'hF800; cf = 1'b0; alu_o = 16'h0050;
    tick(); chk_st("bnc_taken", 8'h50, 16'h0000, 1'b0, 3'b011);
    ex_ir = 16'h0000;

    // idle holds everything
    state = 1'b0;
    tick(); chk_st("idle", 8'h50, 16'h0000, 1'b0, 3'b011);
    chk("idle.i_req", i_req, 1'b0);
    state = 1'b1;

    // JUMP 0x25
    i_datain = 16'hC025;
    tick(); chk_st("jmp_fetch", 8'h51, 16'hC025, 1'b1, 3'b101);
    i_datain = 16'h0000;
    tick(); chk_st("jmp", 8'h25, 16'h0000, 1'b0, 3'b010);
    chk("jmp.flush_cnt", flush_cnt, PERF ? 3 : 0);

    // LOAD r3 then ADD reading r3 in [6:4]
    i_datain = 16'h1300;
    tick(); chk_st("lu_load", 8'h26, 16'h1300, 1'b1, 3'b101);
    i_datain = 16'h4130;
    tick(); chk_st("lu_stall", 8'h26, 16'h0000, 1'b0, 3'b100);
    tick(); chk_st("lu_issue", 8'h27, 16'h4130, 1'b1, 3'b101);
    // LOAD r3 then ADD r1,r1,r2: independent
    i_datain = 16'h1300;
    tick(); chk_st("nolu_load", 8'h28, 16'h1300, 1'b1, 3'b101);
    i_datain = 16'h4112;
    tick(); chk_st("nolu_add", 8'h29, 16'h4112, 1'b1, 3'b101);

    // JMPR to 0xFF, then a 3-cycle miss, then wrap
    ex_ir = 16'hC800; alu_o = 16'h00FF;
    tick(); chk_st("jmpr_ff", 8'hFF, 16'h0000, 1'b0, 3'b011);
    ex_ir = 16'h0000; i_ready = 1'b0;
    tick(); chk_st("miss1", 8'hFF, 16'h0000, 1'b0, 3'b110);
    tick(); chk_st("miss2", 8'hFF, 16'h0000, 1'b0, 3'b110);
    tick(); chk_st("miss3", 8'hFF, 16'h0000, 1'b0, 3'b110);
    chk("miss.stall_cnt", stall_cnt, PERF ? 4 : 0);
    i_ready = 1'b1; i_datain = 16'h4123;
    tick(); chk_st("wrap", 8'h00, 16'h4123, 1'b1, 3'b101);

    // HALT in ID, frozen 5 cycles, then JMPR flush
    i_datain = 16'h0800;
    tick(); chk_st("halt_fetch", 8'h01, 16'h0800, 1'b1, 3'b101);
    i_datain = 16'h4123;
    for (int i = 0; i < 5; i++) begin
      tick();
      chk_st($sformatf("halt%0d", i), 8'h01, 16'h0800, 1'b1, 3'b111);
      chk($sformatf("halt%0d.halted", i), halted, 1'b1);
      chk($sformatf("halt%0d.i_req", i), i_req, 1'b0);
    end
    ex_ir = 16'hC800; alu_o = 16'h0010;
    tick(); chk_st("halt_flush", 8'h10, 16'h0000, 1'b0, 3'b011);
    chk("halt_flush.halted", halted, 1'b0);
    chk("halt_flush.flush_cnt", flush_cnt, PERF ? 5 : 0);
    ex_ir = 16'h0000;

    // async reset in the middle of a miss
    i_ready = 1'b0;
    tick(); chk_st("pre_rst_miss", 8'h10, 16'h0000, 1'b0, 3'b110);
    #2 reset = 1'b0;
    #1 chk_st("async_rst", 8'h00, 16'h0000, 1'b0, 3'b000);
    chk("async_rst.stall_cnt", stall_cnt, 0);
    chk("async_rst.flush_cnt", flush_cnt, 0);
    reset = 1'b1;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
